// File: rtl/alu_seq.sv
// alu_seq: sequential ALU, single-cycle ops plus an iterative shift-add multiplier.
// Latency: 1 cycle for every non-MUL opcode (illegal included), WIDTH+1 cycles for MUL.
// Backpressure: accepts only in IDLE; result/flags hold in DONE until out_ready.
module alu_seq #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       sel,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic             zero,
   output logic             negative,
   output logic             overflow,
   output logic             illegal,
   output logic             out_valid,
   input  logic             out_ready
);
   localparam int SW  = $clog2(WIDTH);
   localparam int MSB = WIDTH - 1;

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_XOR  = 4'd4;
   localparam logic [3:0] OP_SHL  = 4'd5;
   localparam logic [3:0] OP_SHR  = 4'd6;
   localparam logic [3:0] OP_PASS = 4'd7;
   localparam logic [3:0] OP_MUL  = 4'd8;
   localparam logic [3:0] OP_SRA  = 4'd9;
   localparam logic [3:0] OP_NOT  = 4'd10;

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic                 w_accept;
   logic                 w_mul_last;

   // multiplier working registers
   logic [2*WIDTH-1:0]   r_acc;
   logic [2*WIDTH-1:0]   r_mcand;
   logic [WIDTH-1:0]     r_mplier;
   logic [SW-1:0]        r_cnt;
   logic [2*WIDTH-1:0]   w_acc_nxt;

   // registered outputs
   logic [WIDTH-1:0]     r_result;
   logic                 r_carry, r_zero, r_negative, r_overflow, r_illegal;

   // single-cycle datapath
   logic [SW-1:0]        w_shamt;
   logic [WIDTH:0]       w_sum, w_diff, w_shl, w_shr, w_sra;
   logic [WIDTH-1:0]     w_res;
   logic                 w_c, w_v, w_ill;

   assign w_shamt = b[SW-1:0];
   assign w_sum   = {1'b0, a} + {1'b0, b};
   // the extra top bit of the difference is the borrow (a < b)
   assign w_diff  = {1'b0, a} - {1'b0, b};
   // shifts carry one guard bit so the last bit shifted out lands in it
   assign w_shl   = {1'b0, a} << w_shamt;
   assign w_shr   = {a, 1'b0} >> w_shamt;
   assign w_sra   = $signed({a, 1'b0}) >>> w_shamt;

   assign w_accept   = in_valid & in_ready;
   assign w_mul_last = (r_cnt == SW'(WIDTH - 1));
   assign w_acc_nxt  = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

   assign result   = r_result;
   assign carry    = r_carry;
   assign zero     = r_zero;
   assign negative = r_negative;
   assign overflow = r_overflow;
   assign illegal  = r_illegal;

   // combinational result and flags for the one-cycle opcodes
   always_comb begin
      w_res = '0;
      w_c   = 1'b0;
      w_v   = 1'b0;
      w_ill = 1'b0;
      case (sel)
         OP_ADD: begin
            w_res = w_sum[MSB:0];
            w_c   = w_sum[WIDTH];
            w_v   = (a[MSB] == b[MSB]) && (w_sum[MSB] != a[MSB]);
         end
         OP_SUB: begin
            w_res = w_diff[MSB:0];
            w_c   = w_diff[WIDTH];
            w_v   = (a[MSB] != b[MSB]) && (w_diff[MSB] != a[MSB]);
         end
         OP_AND:  w_res = a & b;
         OP_OR:   w_res = a | b;
         OP_XOR:  w_res = a ^ b;
         OP_SHL: begin
            w_res = w_shl[MSB:0];
            w_c   = w_shl[WIDTH];
         end
         OP_SHR: begin
            w_res = w_shr[WIDTH:1];
            w_c   = w_shr[0];
         end
         OP_SRA: begin
            w_res = w_sra[WIDTH:1];
            w_c   = w_sra[0];
         end
         OP_PASS: w_res = a;
         OP_NOT:  w_res = ~a;
         OP_MUL:  w_res = '0;
         default: w_ill = 1'b1;
      endcase
   end

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   // next-state and handshake outputs
   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      case (r_state)
         S_IDLE: begin
            in_ready = !rst;
            if (in_valid) w_state_nxt = (sel == OP_MUL) ? S_BUSY : S_DONE;
         end
         S_BUSY: begin
            if (w_mul_last) w_state_nxt = S_DONE;
         end
         S_DONE: begin
            out_valid = 1'b1;
            if (out_ready) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // operand capture, multiplier iteration and result/flag registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_acc      <= '0;
         r_mcand    <= '0;
         r_mplier   <= '0;
         r_cnt      <= '0;
         r_result   <= '0;
         r_carry    <= 1'b0;
         r_zero     <= 1'b0;
         r_negative <= 1'b0;
         r_overflow <= 1'b0;
         r_illegal  <= 1'b0;
      end else if (w_accept) begin
         r_acc    <= '0;
         r_mcand  <= {{WIDTH{1'b0}}, a};
         r_mplier <= b;
         r_cnt    <= '0;
         if (sel != OP_MUL) begin
            r_result   <= w_res;
            r_carry    <= w_c;
            r_zero     <= (w_res == '0);
            r_negative <= w_res[MSB];
            r_overflow <= w_v;
            r_illegal  <= w_ill;
         end
      end else if (r_state == S_BUSY) begin
         r_acc    <= w_acc_nxt;
         r_mcand  <= r_mcand << 1;
         r_mplier <= r_mplier >> 1;
         r_cnt    <= r_cnt + SW'(1);
         if (w_mul_last) begin
            r_result   <= w_acc_nxt[MSB:0];
            r_carry    <= |w_acc_nxt[2*WIDTH-1:WIDTH];
            r_zero     <= (w_acc_nxt[MSB:0] == '0);
            r_negative <= w_acc_nxt[MSB];
            r_overflow <= 1'b0;
            r_illegal  <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: random traffic on an 8-bit instance checked every cycle against
// an arithmetic reference model, plus directed literal cases on 8- and 16-bit instances.
module tb_alu_seq;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic [3:0] sel;
   logic [7:0] a, b, result;
   logic       in_valid, in_ready, out_valid, out_ready;
   logic       carry, zero, negative, overflow, illegal;

   logic [3:0]  sel16;
   logic [15:0] a16, b16, result16;
   logic        in_valid16, in_ready16, out_valid16, out_ready16;
   logic        carry16, zero16, negative16, overflow16, illegal16;

   alu_seq #(.WIDTH(8)) u_dut (
      .clk(clk), .rst(rst), .sel(sel), .a(a), .b(b),
      .in_valid(in_valid), .in_ready(in_ready), .result(result),
      .carry(carry), .zero(zero), .negative(negative), .overflow(overflow),
      .illegal(illegal), .out_valid(out_valid), .out_ready(out_ready)
   );

   alu_seq #(.WIDTH(16)) u_dut16 (
      .clk(clk), .rst(rst), .sel(sel16), .a(a16), .b(b16),
      .in_valid(in_valid16), .in_ready(in_ready16), .result(result16),
      .carry(carry16), .zero(zero16), .negative(negative16), .overflow(overflow16),
      .illegal(illegal16), .out_valid(out_valid16), .out_ready(out_ready16)
   );

   typedef struct {
      longint res;
      bit     c, z, n, v, il;
      int     due;
   } exp_t;

   int   n_vec = 0;
   int   n_err = 0;
   int   cyc   = 0;
   exp_t q[$];

   function automatic void check(string nm, longint act, longint exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endfunction

   // reference: what the op must produce, from plain integer arithmetic
   function automatic exp_t model(int s, longint x, longint y, int w);
      exp_t   r;
      longint m, half, sx, sy, t, st;
      int     sh;
      r    = '{default: 0};
      m    = (longint'(1) << w) - 1;
      half = longint'(1) << (w - 1);
      sx   = (x >= half) ? x - (m + 1) : x;
      sy   = (y >= half) ? y - (m + 1) : y;
      sh   = int'(y % w);
      case (s)
         0: begin t = x + y; r.res = t & m; r.c = (t > m);
                  st = sx + sy; r.v = (st >= half) || (st < -half); end
         1: begin r.res = (x - y) & m; r.c = (x < y);
                  st = sx - sy; r.v = (st >= half) || (st < -half); end
         2: r.res = x & y;
         3: r.res = x | y;
         4: r.res = x ^ y;
         5: begin r.res = (x << sh) & m; r.c = (sh != 0) && (((x >> (w - sh)) & 1) != 0); end
         6: begin r.res = x >> sh;       r.c = (sh != 0) && (((x >> (sh - 1)) & 1) != 0); end
         7: r.res = x;
         8: begin t = x * y; r.res = t & m; r.c = (t > m); end
         9: begin r.res = (sx >>> sh) & m; r.c = (sh != 0) && (((x >> (sh - 1)) & 1) != 0); end
         10: r.res = (~x) & m;
         default: r.il = 1'b1;
      endcase
      r.z = (r.res == 0);
      r.n = ((r.res >> (w - 1)) & 1) != 0;
      return r;
   endfunction

   // per-cycle compare of the 8-bit instance against the model queue
   always @(negedge clk) begin
      exp_t e;
      cyc++;
      if (rst) begin
         q.delete();
         check("rst_out_valid", out_valid, 0);
         check("rst_result", result, 0);
         check("rst_flags", {carry, zero, negative, overflow, illegal}, 0);
      end else begin
         check("in_ready", in_ready, q.size() == 0);
         if (q.size() == 0)
            check("spurious_out_valid", out_valid, 0);
         else if (cyc < q[0].due)
            check("early_out_valid", out_valid, 0);
         else begin
            check("out_valid", out_valid, 1);
            if (out_valid) begin
               check("result", result, q[0].res);
               check("carry", carry, q[0].c);
               check("zero", zero, q[0].z);
               check("negative", negative, q[0].n);
               check("overflow", overflow, q[0].v);
               check("illegal", illegal, q[0].il);
               if (out_ready) void'(q.pop_front());
            end
         end
         if (in_valid && in_ready) begin
            e     = model(sel, a, b, 8);
            e.due = cyc + ((sel == 4'd8) ? 9 : 1);
            q.push_back(e);
         end
      end
   end

   task automatic wait_accept(input bit wide, output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (wide ? in_ready16 : in_ready) begin
            @(posedge clk); #1;
            ok = 1'b1;
            return;
         end
      end
      check("accept_timeout", 0, 1);
   endtask

   // one op on the 8-bit instance; o.due returns the observed latency
   task automatic run_op(input logic [3:0] s, input logic [7:0] x, input logic [7:0] y,
                         output exp_t o);
      bit ok;
      o = '{default: 0};
      @(posedge clk); #1;
      sel = s; a = x; b = y; in_valid = 1'b1; out_ready = 1'b1;
      wait_accept(1'b0, ok);
      in_valid = 1'b0; sel = 4'($urandom); a = 8'($urandom); b = 8'($urandom);
      if (!ok) return;
      for (int j = 1; j <= 40; j++) begin
         @(negedge clk);
         if (out_valid) begin
            o.res = result; o.c = carry; o.z = zero; o.n = negative;
            o.v = overflow; o.il = illegal; o.due = j;
            return;
         end
      end
      check("done_timeout", 0, 1);
   endtask

   task automatic run_op16(input logic [3:0] s, input logic [15:0] x, input logic [15:0] y,
                           output exp_t o);
      bit ok;
      o = '{default: 0};
      @(posedge clk); #1;
      sel16 = s; a16 = x; b16 = y; in_valid16 = 1'b1; out_ready16 = 1'b1;
      wait_accept(1'b1, ok);
      in_valid16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom);
      if (!ok) return;
      for (int j = 1; j <= 40; j++) begin
         @(negedge clk);
         if (out_valid16) begin
            o.res = result16; o.c = carry16; o.z = zero16; o.n = negative16;
            o.v = overflow16; o.il = illegal16; o.due = j;
            return;
         end
      end
      check("done16_timeout", 0, 1);
   endtask

   initial begin
      exp_t       o, e;
      logic [7:0] exp26 [8] = '{8'd18, 8'd12, 8'd3, 8'd15, 8'd12, 8'd120, 8'd1, 8'd15};

      rst = 1'b1; sel = '0; a = '0; b = '0; in_valid = 1'b0; out_ready = 1'b1;
      sel16 = '0; a16 = '0; b16 = '0; in_valid16 = 1'b0; out_ready16 = 1'b1;

      // hand-computed values pinning the reference model
      e = model(0, 127, 1, 8);
      check("model_add_res", e.res, 128); check("model_add_v", e.v, 1); check("model_add_n", e.n, 1);
      e = model(1, 3, 15, 8);
      check("model_sub_res", e.res, 244); check("model_sub_c", e.c, 1);
      e = model(9, 16'h8000, 4, 16);
      check("model_sra16_res", e.res, 16'hF800);
      e = model(8, 300, 300, 16);
      check("model_mul16_res", e.res, 16'h5F90); check("model_mul16_c", e.c, 1);

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // a=15, b=3 through ADD..PASS A
      for (int i = 0; i < 8; i++) begin
         run_op(4'(i), 8'd15, 8'd3, o);
         check("dir_res", o.res, exp26[i]);
         check("dir_lat", o.due, 1);
      end

      run_op(4'd8, 8'd15, 8'd3, o);
      check("mul_res", o.res, 45); check("mul_c", o.c, 0); check("mul_lat", o.due, 9);
      run_op(4'd8, 8'd200, 8'd2, o);
      check("mul_ovf_res", o.res, 144); check("mul_ovf_c", o.c, 1);

      run_op(4'd0, 8'd127, 8'd1, o);
      check("add127_res", o.res, 128); check("add127_v", o.v, 1);
      check("add127_n", o.n, 1); check("add127_c", o.c, 0);
      run_op(4'd0, 8'd255, 8'd1, o);
      check("add255_res", o.res, 0); check("add255_c", o.c, 1); check("add255_z", o.z, 1);
      run_op(4'd1, 8'd3, 8'd15, o);
      check("sub_res", o.res, 244); check("sub_c", o.c, 1);
      run_op(4'd5, 8'h81, 8'd8, o);
      check("shl_amt0_res", o.res, 8'h81); check("shl_amt0_c", o.c, 0);

      // stall in DONE while inputs wiggle
      @(posedge clk); #1;
      sel = 4'd0; a = 8'd10; b = 8'd20; in_valid = 1'b1; out_ready = 1'b0;
      wait_accept(1'b0, o.il);
      for (int j = 0; j < 6; j++) begin
         @(negedge clk);
         check("hold_res", result, 30);
         check("hold_vld", out_valid, 1);
         check("hold_rdy", in_ready, 0);
         @(posedge clk); #1;
         a = 8'($urandom); b = 8'($urandom); sel = 4'($urandom); in_valid = ~in_valid;
      end
      in_valid = 1'b0; out_ready = 1'b1;

      // reset in the middle of a multiply
      @(posedge clk); #1;
      sel = 4'd8; a = 8'd15; b = 8'd3; in_valid = 1'b1;
      wait_accept(1'b0, o.il);
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("post_rst_res", result, 0);
      check("post_rst_flags", {carry, zero, negative, overflow, illegal}, 0);
      check("post_rst_rdy", in_ready, 1);
      for (int j = 0; j < 15; j++) begin
         @(negedge clk);
         check("aborted_vld", out_valid, 0);
      end
      run_op(4'b1100, 8'd7, 8'd9, o);
      check("ill_res", o.res, 0); check("ill_z", o.z, 1); check("ill_il", o.il, 1);
      check("ill_flags", {o.c, o.n, o.v}, 0); check("ill_lat", o.due, 1);

      // 16-bit instance
      run_op16(4'd9, 16'h8000, 16'd4, o);
      check("sra16_res", o.res, 16'hF800); check("sra16_n", o.n, 1);
      e = model(9, 16'h8000, 4, 16);
      check("sra16_model_c", o.c, e.c);
      run_op16(4'd8, 16'd300, 16'd300, o);
      check("mul16_res", o.res, 16'h5F90); check("mul16_c", o.c, 1); check("mul16_lat", o.due, 17);

      // random traffic with random backpressure and occasional resets
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk); #1;
         in_valid  = ($urandom_range(0, 2) != 0);
         sel       = 4'($urandom_range(0, 15));
         a         = 8'($urandom);
         b         = 8'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         rst       = ($urandom_range(0, 299) == 0);
      end
      @(posedge clk); #1;
      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      repeat (20) @(posedge clk);
      @(negedge clk);
      check("drain", q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
